// File: rtl/arcade_input_mapper.sv
// Player-input front end: PS/2 key decode, joystick merge, rotation remap and coin pulse stretcher.
// Define ARCADE_INPUT_AUTOFIRE_EN to build the per-player autofire counters.
module arcade_input_mapper #(
   parameter int unsigned NPLAYERS    = 2,
   parameter int unsigned COIN_CYCLES = 300000,
   parameter int unsigned AF_HALF     = 1500000
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic [10:0]            ps2_key,
   input  logic [16*NPLAYERS-1:0] joystick,
   input  logic [1:0]             rot,
   input  logic [NPLAYERS-1:0]    autofire,
   output logic [NPLAYERS-1:0]    up,
   output logic [NPLAYERS-1:0]    down,
   output logic [NPLAYERS-1:0]    left,
   output logic [NPLAYERS-1:0]    right,
   output logic [NPLAYERS-1:0]    fire,
   output logic                   start1,
   output logic                   start2,
   output logic                   coin
);

   localparam int unsigned COIN_W = $clog2(COIN_CYCLES);
   localparam int unsigned NKEYS  = 12;
   localparam int unsigned K_UP    = 0;
   localparam int unsigned K_DOWN  = 1;
   localparam int unsigned K_LEFT  = 2;
   localparam int unsigned K_RIGHT = 3;
   localparam int unsigned K_SPACE = 4;
   localparam int unsigned K_CTRL  = 5;
   localparam int unsigned K_F1    = 6;
   localparam int unsigned K_1     = 7;
   localparam int unsigned K_F2    = 8;
   localparam int unsigned K_2     = 9;
   localparam int unsigned K_F3    = 10;
   localparam int unsigned K_5     = 11;

   typedef enum logic [1:0] {
      C_IDLE,
      C_PULSE,
      C_GAP
   } coin_state_t;

   // Extended flag and joystick bits 8..15 carry nothing this block decodes.
   logic unused_ok;
   assign unused_ok = ^{ps2_key[8], joystick, autofire};

   logic             toggle_q;
   logic [NKEYS-1:0] keys_q;
   logic [NKEYS-1:0] keys_d;

   // Key decode: an event is any difference between the toggle bit and its tracked copy.
   always_comb begin
      keys_d = keys_q;
      if (ps2_key[10] != toggle_q) begin
         case (ps2_key[7:0])
            8'h75:   keys_d[K_UP]    = ps2_key[9];
            8'h72:   keys_d[K_DOWN]  = ps2_key[9];
            8'h6B:   keys_d[K_LEFT]  = ps2_key[9];
            8'h74:   keys_d[K_RIGHT] = ps2_key[9];
            8'h29:   keys_d[K_SPACE] = ps2_key[9];
            8'h14:   keys_d[K_CTRL]  = ps2_key[9];
            8'h05:   keys_d[K_F1]    = ps2_key[9];
            8'h16:   keys_d[K_1]     = ps2_key[9];
            8'h06:   keys_d[K_F2]    = ps2_key[9];
            8'h1E:   keys_d[K_2]     = ps2_key[9];
            8'h04:   keys_d[K_F3]    = ps2_key[9];
            8'h2E:   keys_d[K_5]     = ps2_key[9];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      toggle_q <= ps2_key[10];
      if (reset) begin
         keys_q <= '0;
      end else begin
         keys_q <= keys_d;
      end
   end

   logic [NPLAYERS-1:0] p_up, p_dn, p_lf, p_rt, p_fire;
   logic [NPLAYERS-1:0] l_up, l_dn, l_lf, l_rt;
   logic                start1_c, start2_c, coin_req_c;

   // Physical inputs per player; keyboard merges into player 0 only.
   always_comb begin
      start1_c   = keys_q[K_F1] | keys_q[K_1];
      start2_c   = keys_q[K_F2] | keys_q[K_2];
      coin_req_c = keys_q[K_F3] | keys_q[K_5];
      for (int n = 0; n < int'(NPLAYERS); n++) begin
         p_rt[n]    = joystick[16*n + 0];
         p_lf[n]    = joystick[16*n + 1];
         p_dn[n]    = joystick[16*n + 2];
         p_up[n]    = joystick[16*n + 3];
         p_fire[n]  = joystick[16*n + 4];
         start1_c   = start1_c   | joystick[16*n + 5];
         start2_c   = start2_c   | joystick[16*n + 6];
         coin_req_c = coin_req_c | joystick[16*n + 7];
      end
      p_up[0]   = p_up[0]   | keys_q[K_UP];
      p_dn[0]   = p_dn[0]   | keys_q[K_DOWN];
      p_lf[0]   = p_lf[0]   | keys_q[K_LEFT];
      p_rt[0]   = p_rt[0]   | keys_q[K_RIGHT];
      p_fire[0] = p_fire[0] | keys_q[K_SPACE] | keys_q[K_CTRL];
   end

   // Screen rotation: each logical direction selects one physical direction.
   always_comb begin
      l_up = p_up;
      l_dn = p_dn;
      l_lf = p_lf;
      l_rt = p_rt;
      case (rot)
         2'd1: begin
            l_lf = p_dn;
            l_rt = p_up;
            l_up = p_lf;
            l_dn = p_rt;
         end
         2'd2: begin
            l_lf = p_rt;
            l_rt = p_lf;
            l_up = p_dn;
            l_dn = p_up;
         end
         2'd3: begin
            l_lf = p_up;
            l_rt = p_dn;
            l_up = p_rt;
            l_dn = p_lf;
         end
         default: ;
      endcase
   end

   logic [NPLAYERS-1:0] fire_d;

`ifdef ARCADE_INPUT_AUTOFIRE_EN
   localparam int unsigned AF_W = $clog2(AF_HALF + 1);

   logic [AF_W-1:0]     af_cnt_q [NPLAYERS];
   logic [NPLAYERS-1:0] af_phase_q;

   // Phase 0 drives fire high; the phase flips every AF_HALF held cycles.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         for (int n = 0; n < int'(NPLAYERS); n++) begin
            af_cnt_q[n] <= '0;
         end
         af_phase_q <= '0;
      end else begin
         for (int n = 0; n < int'(NPLAYERS); n++) begin
            if (autofire[n] && p_fire[n]) begin
               if (af_cnt_q[n] == AF_W'(AF_HALF - 1)) begin
                  af_cnt_q[n]   <= '0;
                  af_phase_q[n] <= ~af_phase_q[n];
               end else begin
                  af_cnt_q[n] <= af_cnt_q[n] + AF_W'(1);
               end
            end else begin
               af_cnt_q[n]   <= '0;
               af_phase_q[n] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      fire_d = p_fire;
      for (int n = 0; n < int'(NPLAYERS); n++) begin
         if (autofire[n] && p_fire[n]) begin
            fire_d[n] = ~af_phase_q[n];
         end
      end
   end
`else
   always_comb begin
      fire_d = p_fire;
   end
`endif

   coin_state_t       coin_state_q, coin_state_d;
   logic [COIN_W-1:0] coin_cnt_q, coin_cnt_d;
   logic              coin_req_q;

   // Loading the request history during reset keeps a held level from looking like an edge.
   always_ff @(posedge clk_sys) begin
      coin_req_q <= coin_req_c;
      if (reset) begin
         coin_state_q <= C_IDLE;
         coin_cnt_q   <= '0;
      end else begin
         coin_state_q <= coin_state_d;
         coin_cnt_q   <= coin_cnt_d;
      end
   end

   always_comb begin
      coin_state_d = coin_state_q;
      coin_cnt_d   = coin_cnt_q;
      case (coin_state_q)
         C_IDLE: begin
            if (coin_req_c && !coin_req_q) begin
               coin_state_d = C_PULSE;
               coin_cnt_d   = COIN_W'(COIN_CYCLES - 1);
            end
         end
         C_PULSE: begin
            if (coin_cnt_q == '0) begin
               coin_state_d = C_GAP;
               coin_cnt_d   = COIN_W'(COIN_CYCLES - 1);
            end else begin
               coin_cnt_d = coin_cnt_q - COIN_W'(1);
            end
         end
         C_GAP: begin
            if (coin_cnt_q == '0) begin
               coin_state_d = C_IDLE;
            end else begin
               coin_cnt_d = coin_cnt_q - COIN_W'(1);
            end
         end
         default: coin_state_d = C_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         up     <= '0;
         down   <= '0;
         left   <= '0;
         right  <= '0;
         fire   <= '0;
         start1 <= 1'b0;
         start2 <= 1'b0;
         coin   <= 1'b0;
      end else begin
         up     <= l_up;
         down   <= l_dn;
         left   <= l_lf;
         right  <= l_rt;
         fire   <= fire_d;
         start1 <= start1_c;
         start2 <= start2_c;
         coin   <= (coin_state_d == C_PULSE);
      end
   end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: key decode, merge, rotation, start OR, coin stretcher, autofire.
module tb_arcade_input_mapper;

   localparam int unsigned NPLAYERS    = 2;
   localparam int unsigned COIN_CYCLES = 4;
   localparam int unsigned AF_HALF     = 3;

   logic                   clk_sys = 1'b0;
   logic                   reset;
   logic [10:0]            ps2_key;
   logic [16*NPLAYERS-1:0] joystick;
   logic [1:0]             rot;
   logic [NPLAYERS-1:0]    autofire;
   logic [NPLAYERS-1:0]    up, down, left, right, fire;
   logic                   start1, start2, coin;

   int n_cmp = 0;
   int n_err = 0;

   logic [11:0] af_exp;

   always #5 clk_sys = ~clk_sys;

   arcade_input_mapper #(
      .NPLAYERS   (NPLAYERS),
      .COIN_CYCLES(COIN_CYCLES),
      .AF_HALF    (AF_HALF)
   ) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .ps2_key (ps2_key),
      .joystick(joystick),
      .rot     (rot),
      .autofire(autofire),
      .up      (up),
      .down    (down),
      .left    (left),
      .right   (right),
      .fire    (fire),
      .start1  (start1),
      .start2  (start2),
      .coin    (coin)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
      ps2_key = {~ps2_key[10], pressed, ext, code};
   endtask

   // Direction bundle: up[7:6] down[5:4] left[3:2] right[1:0], player 1 in the upper bit of each pair.
   function automatic logic [15:0] dirs();
      return 16'({up, down, left, right});
   endfunction

   function automatic logic [15:0] all_outs();
      return 16'({up, down, left, right, fire, start1, start2, coin});
   endfunction

   initial begin
      reset    = 1'b1;
      ps2_key  = 11'h400;
      joystick = '0;
      rot      = 2'd0;
      autofire = '0;
      tick(3);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("rst_quiet", all_outs(), 16'h0000);
      end

      send_key(1'b1, 1'b0, 8'h75);
      tick();
      check("up_lat1", dirs(), 16'h0000);
      tick();
      check("up_press", dirs(), 16'h0040);
      send_key(1'b0, 1'b0, 8'h75);
      tick(2);
      check("up_release", dirs(), 16'h0000);

      send_key(1'b1, 1'b1, 8'h6B);
      tick(2);
      check("ext_left", dirs(), 16'h0004);
      send_key(1'b0, 1'b1, 8'h6B);
      tick(2);
      check("ext_left_rel", dirs(), 16'h0000);

      send_key(1'b1, 1'b0, 8'h1C);
      tick(2);
      check("unmatched", all_outs(), 16'h0000);
      send_key(1'b0, 1'b0, 8'h1C);
      tick(2);

      send_key(1'b1, 1'b0, 8'h72);
      joystick[0] = 1'b1;
      tick();
      check("simul_joy", dirs(), 16'h0001);
      tick();
      check("simul_both", dirs(), 16'h0011);
      send_key(1'b0, 1'b0, 8'h72);
      joystick[0] = 1'b0;
      tick(2);
      check("simul_clear", dirs(), 16'h0000);

      joystick[17] = 1'b1;
      rot = 2'd0;
      tick();
      check("rot0_left", dirs(), 16'h0008);
      rot = 2'd1;
      tick();
      check("rot1_left", dirs(), 16'h0080);
      rot = 2'd2;
      tick();
      check("rot2_left", dirs(), 16'h0002);
      rot = 2'd3;
      tick();
      check("rot3_left", dirs(), 16'h0020);
      joystick[17] = 1'b0;
      joystick[18] = 1'b1;
      rot = 2'd1;
      tick();
      check("rot1_down", dirs(), 16'h0008);
      joystick[18] = 1'b0;
      rot = 2'd0;
      tick();
      check("rot_clear", dirs(), 16'h0000);

      send_key(1'b1, 1'b0, 8'h05);
      tick(2);
      check("start1_kb", 16'({start1, start2}), 16'h0002);
      joystick[5] = 1'b1;
      tick();
      check("start1_both", 16'({start1, start2}), 16'h0002);
      send_key(1'b0, 1'b0, 8'h05);
      tick(2);
      check("start1_joy_hold", 16'({start1, start2}), 16'h0002);
      joystick[5] = 1'b0;
      tick();
      check("start1_off", 16'({start1, start2}), 16'h0000);
      joystick[22] = 1'b1;
      tick();
      check("start2_p1", 16'({start1, start2}), 16'h0001);
      joystick[22] = 1'b0;
      tick();

      send_key(1'b1, 1'b0, 8'h2E);
      tick();
      check("coin_lat", 16'(coin), 16'h0000);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("coin_pulse", 16'(coin), 16'h0001);
      end
      tick();
      check("coin_gap", 16'(coin), 16'h0000);
      send_key(1'b0, 1'b0, 8'h2E);
      tick();
      check("coin_gap", 16'(coin), 16'h0000);
      send_key(1'b1, 1'b0, 8'h2E);
      for (int i = 0; i < 7; i++) begin
         tick();
         check("coin_gap_press", 16'(coin), 16'h0000);
      end
      send_key(1'b0, 1'b0, 8'h2E);
      tick(2);
      send_key(1'b1, 1'b0, 8'h2E);
      tick();
      check("coin2_lat", 16'(coin), 16'h0000);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("coin2_pulse", 16'(coin), 16'h0001);
      end
      tick();
      check("coin2_end", 16'(coin), 16'h0000);
      send_key(1'b0, 1'b0, 8'h2E);
      tick(2);

`ifdef ARCADE_INPUT_AUTOFIRE_EN
      af_exp = 12'b111000111000;
`else
      af_exp = 12'b111111111111;
`endif
      autofire = 2'b01;
      send_key(1'b1, 1'b0, 8'h29);
      tick();
      check("af_lat", 16'(fire), 16'h0000);
      for (int i = 0; i < 12; i++) begin
         tick();
         check("af_pattern", 16'(fire), 16'(af_exp[11-i]));
      end
      send_key(1'b0, 1'b0, 8'h29);
      tick(2);
      check("af_release", 16'(fire), 16'h0000);

      joystick[4] = 1'b1;
      tick();
      check("af_joy_first", 16'(fire), 16'h0001);
      joystick[4] = 1'b0;
      tick();
      check("af_joy_release", 16'(fire), 16'h0000);

      joystick[20] = 1'b1;
      tick();
      check("fire_p1_pass", 16'(fire), 16'h0002);
      joystick[20] = 1'b0;
      tick();
      check("fire_p1_off", 16'(fire), 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
